vga_timing_monitor: RTL and testbench

- Synthesizable checker that sits directly downstream of top_vga's output pins, in parallel with the bench's image dump.
- Consumes hs, vs and 4-bit r/g/b, measures line and frame timing against the 1024x768@60 (65 MHz) raster, and raises sticky timing errors.
- Produces a per-frame pixel checksum, so regression benches can compare frames numerically instead of by image diff.
- Also usable on-chip behind debug LEDs/UART.

---
 rtl/vga_timing_monitor.sv | 107 ++++++++++
 tb/tb_vga_timing_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: checks hs/vs raster timing against the expected totals,
// raises sticky errors, tracks lock and produces a per-frame pixel checksum.
module vga_timing_monitor #(
   parameter int   H_TOTAL    = 1344,
   parameter int   V_TOTAL    = 806,
   parameter int   H_SYNC_LEN = 136,
   parameter int   V_SYNC_LEN = 6,
   parameter logic SYNC_POL   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hs,
   input  logic        vs,
   input  logic [3:0]  r,
   input  logic [3:0]  g,
   input  logic [3:0]  b,
   input  logic        err_clr,
   output logic        locked,
   output logic        h_err,
   output logic        v_err,
   output logic [10:0] h_meas,
   output logic [9:0]  v_meas,
   output logic [15:0] frame_cnt,
   output logic [31:0] frame_sum,
   output logic        frame_done
);
   localparam logic [10:0] HT  = 11'(H_TOTAL);
   localparam logic [10:0] HSL = 11'(H_SYNC_LEN);
   localparam logic [9:0]  VT  = 10'(V_TOTAL);
   localparam logic [9:0]  VSL = 10'(V_SYNC_LEN);
   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
   state_t state, state_nxt;
   logic hs_d1, hs_d2, vs_d1, vs_d2;
   logic [11:0] px_d1, px_d2;
   logic [10:0] hc, hw;
   logic [9:0] vc, vw;
   logic [31:0] acc;
   logic h_skip, frame_bad;
   logic hs_ae, hs_de, vs_ae, vs_de, active, h_chk, h_bad, v_bad;
   assign hs_ae  = (hs_d1 == SYNC_POL) && (hs_d2 != SYNC_POL);
   assign hs_de  = (hs_d1 != SYNC_POL) && (hs_d2 == SYNC_POL);
   assign vs_ae  = (vs_d1 == SYNC_POL) && (vs_d2 != SYNC_POL);
   assign vs_de  = (vs_d1 != SYNC_POL) && (vs_d2 == SYNC_POL);
   assign active = state != SEARCH;
   // the first line after leaving SEARCH may be partial, so its period is not judged
   assign h_chk  = active && hs_ae && !h_skip;
   assign h_bad  = (h_chk && hc != HT) || (active && hs_de && hw != HSL);
   assign v_bad  = active && ((vs_ae && vc != VT) || (vs_de && vw != VSL));
   assign locked = state == LOCKED;
   always_comb begin
      state_nxt = state;
      state_nxt = state == SEARCH ? (vs_ae ? MEASURE : SEARCH)
                : (h_bad || v_bad) ? MEASURE
                : (state == MEASURE && vs_ae && !frame_bad) ? LOCKED : state;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= SEARCH;
      else     state <= state_nxt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_d1      <= ~SYNC_POL;
         hs_d2      <= ~SYNC_POL;
         vs_d1      <= ~SYNC_POL;
         vs_d2      <= ~SYNC_POL;
         px_d1      <= '0;
         px_d2      <= '0;
         hc         <= '0;
         hw         <= '0;
         vc         <= '0;
         vw         <= '0;
         acc        <= '0;
         h_skip     <= 1'b1;
         frame_bad  <= 1'b0;
         h_err      <= 1'b0;
         v_err      <= 1'b0;
         h_meas     <= '0;
         v_meas     <= '0;
         frame_cnt  <= '0;
         frame_sum  <= '0;
         frame_done <= 1'b0;
      end else begin
         hs_d1      <= hs;
         hs_d2      <= hs_d1;
         vs_d1      <= vs;
         vs_d2      <= vs_d1;
         px_d1      <= {r, g, b};
         px_d2      <= px_d1;
         hc         <= hs_ae ? 11'd1 : hc + {10'd0, ~&hc};
         hw         <= hs_ae ? 11'd1 : hw + {10'd0, hs_d1 == SYNC_POL && ~&hw};
         // an hs edge coincident with the vs edge is the first line of the new frame
         vc         <= vs_ae ? {9'd0, hs_ae} : vc + {9'd0, hs_ae && ~&vc};
         vw         <= vs_ae ? {9'd0, hs_ae} : vw + {9'd0, hs_ae && vs_d1 == SYNC_POL && ~&vw};
         acc        <= vs_ae ? {20'd0, px_d2} : acc + {20'd0, px_d2};
         h_skip     <= !active || (h_skip && !hs_ae);
         frame_bad  <= !vs_ae && (frame_bad || h_bad || v_bad);
         h_err      <= h_bad || (h_err && !err_clr);
         v_err      <= v_bad || (v_err && !err_clr);
         frame_done <= active && vs_ae;
         if (h_chk) h_meas <= hc;
         if (active && vs_ae) begin
            v_meas    <= vc;
            frame_sum <= acc;
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: drives a scaled raster and scoreboards every frame_done.
module tb_vga_timing_monitor;
   localparam int HT = 48;
   localparam int HS = 6;
   localparam int VT = 14;
   localparam int VS = 3;
   logic clk = 1'b0;
   logic rst, hs, vs, err_clr;
   logic [3:0] r, g, b;
   logic locked, h_err, v_err, frame_done;
   logic [10:0] h_meas;
   logic [9:0] v_meas;
   logic [15:0] frame_cnt;
   logic [31:0] frame_sum;
   typedef struct {
      logic [10:0] hm;
      logic [9:0]  vm;
      logic [31:0] sum;
      logic [15:0] cnt;
      logic        lk;
   } exp_t;
   exp_t q[$];
   exp_t got_e;
   int vectors = 0;
   int errs = 0;
   int m_state = 0;
   int seed = 0;
   logic [15:0] cnt = '0;
   logic [31:0] cur_sum = '0;
   logic [11:0] last_px = '0;
   logic fbad = 1'b0;
   logic eh = 1'b0;
   logic ev = 1'b0;
   logic chk_const = 1'b0;
   logic chk_nom = 1'b0;
   vga_timing_monitor #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_LEN(HS), .V_SYNC_LEN(VS), .SYNC_POL(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b), .err_clr(err_clr),
      .locked(locked), .h_err(h_err), .v_err(v_err), .h_meas(h_meas), .v_meas(v_meas),
      .frame_cnt(frame_cnt), .frame_sum(frame_sum), .frame_done(frame_done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic chk_zero(input string when);
      chk({when, "_locked"}, 32'(locked), 0);
      chk({when, "_h_err"}, 32'(h_err), 0);
      chk({when, "_v_err"}, 32'(v_err), 0);
      chk({when, "_h_meas"}, 32'(h_meas), 0);
      chk({when, "_v_meas"}, 32'(v_meas), 0);
      chk({when, "_frame_cnt"}, 32'(frame_cnt), 0);
      chk({when, "_frame_sum"}, frame_sum, 0);
      chk({when, "_frame_done"}, 32'(frame_done), 0);
   endtask
   // previous frame's window runs from one sample before its vs start up to two before this one
   task automatic frame_start();
      exp_t e;
      if (m_state == 0) m_state = 1;
      else begin
         cnt++;
         m_state = fbad ? 1 : 2;
         e.hm  = 11'(HT);
         e.vm  = 10'(VT);
         e.sum = cur_sum - {20'd0, last_px};
         e.cnt = cnt;
         e.lk  = m_state == 2;
         q.push_back(e);
      end
      cur_sum = {20'd0, last_px};
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         hs = 1'b1;
         vs = 1'b1;
         {r, g, b} = '0;
         err_clr = 1'b0;
         last_px = '0;
      end
   endtask
   task automatic run_frame(input int long_line, input int vs_len, input bit konst,
                            input int clr_line, input int stop_line);
      logic [11:0] px;
      for (int y = 0; y < VT; y++) begin
         if (y == stop_line) return;
         for (int x = 0; x < HT + int'(y == long_line); x++) begin
            @(negedge clk);
            if (y == 0 && x == 0) begin
               frame_start();
               fbad = (long_line >= 0) || (vs_len != VS);
               seed++;
            end
            if (y == 0 && x == 4 && chk_const) begin
               chk("const_sum", frame_sum, 32'(HT * VT * 4095));
               chk_const = 1'b0;
            end
            if (y == 2 && x == 0 && chk_nom) begin
               chk("nom_locked", 32'(locked), 1);
               chk("nom_h_err", 32'(h_err), 0);
               chk("nom_v_err", 32'(v_err), 0);
               chk("nom_h_meas", 32'(h_meas), HT);
               chk("nom_v_meas", 32'(v_meas), VT);
               chk_nom = 1'b0;
            end
            if (long_line >= 0 && y == long_line + 1 && x == 3) begin
               chk("long_h_err", 32'(h_err), 1);
               chk("long_locked", 32'(locked), 0);
               eh = 1'b1;
            end
            if (vs_len != VS && y == vs_len && x == 3) begin
               chk("short_v_err", 32'(v_err), 1);
               ev = 1'b1;
            end
            if (y == clr_line && x == 0) begin
               chk("pre_clr_h_err", 32'(h_err), 32'(eh));
               chk("pre_clr_v_err", 32'(v_err), 32'(ev));
            end
            if (y == clr_line && x == 6) begin
               eh = (clr_line == long_line + 1);
               ev = 1'b0;
               chk("clr_h_err", 32'(h_err), 32'(eh));
               chk("clr_v_err", 32'(v_err), 0);
            end
            px = konst ? 12'hfff
               : (x >= 10 && x < 46 && y >= 4 && y < 12) ? 12'(x * 7 + y * 131 + seed) : 12'h000;
            hs = (x < HS) ? 1'b0 : 1'b1;
            vs = (y < vs_len) ? 1'b0 : 1'b1;
            {r, g, b} = px;
            err_clr = (y == clr_line && x == 1);
            cur_sum += {20'd0, px};
            last_px = px;
         end
      end
   endtask
   always @(negedge clk)
      if (!rst && frame_done) begin
         if (q.size() == 0) chk("unexpected_done", 32'(frame_done), 0);
         else begin
            got_e = q.pop_front();
            chk("fd_h_meas", 32'(h_meas), 32'(got_e.hm));
            chk("fd_v_meas", 32'(v_meas), 32'(got_e.vm));
            chk("fd_frame_sum", frame_sum, got_e.sum);
            chk("fd_frame_cnt", 32'(frame_cnt), 32'(got_e.cnt));
            chk("fd_locked", 32'(locked), 32'(got_e.lk));
         end
      end
   initial begin
      rst = 1'b1;
      hs = 1'b1;
      vs = 1'b1;
      {r, g, b} = '0;
      err_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      idle(10);
      repeat (3) run_frame(-1, VS, 0, -1, -1);
      chk_nom = 1'b1;
      run_frame(-1, VS, 0, -1, -1);
      run_frame(-1, VS, 1, -1, -1);
      run_frame(-1, VS, 1, -1, -1);
      chk_const = 1'b1;
      run_frame(-1, VS, 0, -1, -1);
      run_frame(5, VS, 0, -1, -1);
      run_frame(-1, VS, 0, -1, -1);
      run_frame(-1, VS, 0, 7, -1);
      run_frame(-1, 2, 0, 8, -1);
      run_frame(-1, VS, 0, -1, -1);
      run_frame(-1, VS, 0, -1, -1);
      run_frame(3, VS, 0, 4, -1);
      run_frame(-1, VS, 0, -1, -1);
      run_frame(-1, VS, 0, -1, -1);
      run_frame(-1, VS, 0, -1, 5);
      @(negedge clk);
      chk("pre_rst_locked", 32'(locked), 1);
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      hs = 1'b1;
      vs = 1'b1;
      {r, g, b} = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_state = 0;
      cnt = '0;
      eh = 1'b0;
      ev = 1'b0;
      idle(10);
      repeat (3) run_frame(-1, VS, 0, -1, -1);
      chk_nom = 1'b1;
      run_frame(-1, VS, 0, -1, -1);
      run_frame(-1, VS, 0, -1, 1);
      idle(5);
      chk("pending", 32'(q.size()), 0);
      chk("end_frame_cnt", 32'(frame_cnt), 4);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
